// File: rtl/vx_stream_rr_arbiter.sv
// Round-robin arbiter over NUM_INPUTS valid/ready streams with a single-entry
// output pipe register carrying the winning payload and its source index.
module vx_stream_rr_arbiter #(
  parameter int NUM_INPUTS = 4,
  parameter int DATAW      = 32,
  parameter int LN         = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_INPUTS-1:0]            valid_in,
  input  logic [NUM_INPUTS-1:0][DATAW-1:0] data_in,
  output logic [NUM_INPUTS-1:0]            ready_in,
  output logic                             valid_out,
  output logic [DATAW-1:0]                 data_out,
  output logic [LN-1:0]                    sel_out,
  input  logic                             ready_out
);

  logic             w_en;
  logic             w_any;
  logic [DATAW-1:0] w_data;
  logic             r_valid;
  logic [DATAW-1:0] r_data;

  // Load when empty or draining, so an accept and a drain share one cycle.
  assign w_en  = ~r_valid | ready_out;
  assign w_any = |valid_in;

  generate
    if (NUM_INPUTS == 1) begin : g_single
      assign ready_in[0] = w_en;
      assign w_data      = data_in[0];
      assign sel_out     = '0;
    end else begin : g_multi
      logic [LN-1:0] r_ptr;
      logic [LN-1:0] r_sel;
      logic [LN-1:0] w_grant;
      logic [LN:0]   w_idx;
      logic          w_found;

      // Scan from r_ptr upward, wrapping at NUM_INPUTS; the extra index bit
      // keeps the sum from overflowing before the wrap subtraction.
      always_comb begin
        w_grant = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int j = 0; j < NUM_INPUTS; j++) begin
          w_idx = {1'b0, r_ptr} + (LN+1)'(j);
          if (w_idx >= (LN+1)'(NUM_INPUTS)) begin
            w_idx = w_idx - (LN+1)'(NUM_INPUTS);
          end
          if (!w_found && valid_in[w_idx[LN-1:0]]) begin
            w_grant = w_idx[LN-1:0];
            w_found = 1'b1;
          end
        end
      end

      for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_ready
        assign ready_in[gi] = w_en & w_any & (w_grant == LN'(gi));
      end

      assign w_data  = data_in[w_grant];
      assign sel_out = r_sel;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_ptr <= '0;
          r_sel <= '0;
        end else if (w_en && w_any) begin
          r_sel <= w_grant;
          r_ptr <= (w_grant == LN'(NUM_INPUTS - 1)) ? '0 : w_grant + 1'b1;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (w_en) begin
      r_valid <= w_any;
      if (w_any) begin
        r_data <= w_data;
      end
    end
  end

  assign valid_out = r_valid;
  assign data_out  = r_data;

endmodule

// File: tb/tb_vx_stream_rr_arbiter.sv
// Bench for vx_stream_rr_arbiter: three instances (N=4, N=3, N=1/DATAW=8)
// driven side by side and compared against a queue-free arithmetic model.
module tb_vx_stream_rr_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  vin  [3];
  logic [31:0] din  [3][4];
  logic        rout [3];

  logic [3:0]  o_rdy [3];
  logic        o_vld [3];
  logic [31:0] o_dat [3];
  logic [1:0]  o_sel [3];

  // Instance 0: N=4
  logic [3:0]       d0_vi, d0_ri;
  logic [3:0][31:0] d0_di;
  logic             d0_vo;
  logic [31:0]      d0_do;
  logic [1:0]       d0_so;
  assign d0_vi = vin[0];
  assign d0_di = {din[0][3], din[0][2], din[0][1], din[0][0]};

  vx_stream_rr_arbiter #(.NUM_INPUTS(4), .DATAW(32)) u_dut4 (
    .clk(clk), .reset(reset), .valid_in(d0_vi), .data_in(d0_di),
    .ready_in(d0_ri), .valid_out(d0_vo), .data_out(d0_do),
    .sel_out(d0_so), .ready_out(rout[0])
  );

  // Instance 1: N=3
  logic [2:0]       d1_vi, d1_ri;
  logic [2:0][31:0] d1_di;
  logic             d1_vo;
  logic [31:0]      d1_do;
  logic [1:0]       d1_so;
  assign d1_vi = vin[1][2:0];
  assign d1_di = {din[1][2], din[1][1], din[1][0]};

  vx_stream_rr_arbiter #(.NUM_INPUTS(3), .DATAW(32)) u_dut3 (
    .clk(clk), .reset(reset), .valid_in(d1_vi), .data_in(d1_di),
    .ready_in(d1_ri), .valid_out(d1_vo), .data_out(d1_do),
    .sel_out(d1_so), .ready_out(rout[1])
  );

  // Instance 2: N=1, DATAW=8
  logic [0:0]      d2_vi, d2_ri;
  logic [0:0][7:0] d2_di;
  logic            d2_vo;
  logic [7:0]      d2_do;
  logic [0:0]      d2_so;
  assign d2_vi = vin[2][0];
  assign d2_di = din[2][0][7:0];

  vx_stream_rr_arbiter #(.NUM_INPUTS(1), .DATAW(8)) u_dut1 (
    .clk(clk), .reset(reset), .valid_in(d2_vi), .data_in(d2_di),
    .ready_in(d2_ri), .valid_out(d2_vo), .data_out(d2_do),
    .sel_out(d2_so), .ready_out(rout[2])
  );

  assign o_rdy[0] = d0_ri;
  assign o_rdy[1] = {1'b0, d1_ri};
  assign o_rdy[2] = {3'b000, d2_ri};
  assign o_vld[0] = d0_vo;
  assign o_vld[1] = d1_vo;
  assign o_vld[2] = d2_vo;
  assign o_dat[0] = d0_do;
  assign o_dat[1] = d1_do;
  assign o_dat[2] = {24'h0, d2_do};
  assign o_sel[0] = d0_so;
  assign o_sel[1] = d1_so;
  assign o_sel[2] = {1'b0, d2_so};

  // Reference model state
  int          m_ptr [3];
  logic        m_vld [3];
  logic [31:0] m_dat [3];
  int          m_sel [3];

  int compared = 0;
  int mism     = 0;
  int phase_cnt = 0;

  function automatic int nof(input int k);
    return (k == 0) ? 4 : ((k == 1) ? 3 : 1);
  endfunction

  function automatic logic [3:0] vmask(input int k);
    return 4'((1 << nof(k)) - 1);
  endfunction

  // Winner = first valid stream at or after the pointer, cyclically.
  function automatic int grant_of(input int k);
    for (int j = 0; j < nof(k); j++) begin
      int idx;
      idx = (m_ptr[k] + j) % nof(k);
      if (vin[k][idx]) return idx;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_ptr[k] = 0;
      m_vld[k] = 1'b0;
      m_dat[k] = '0;
      m_sel[k] = 0;
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      int g;
      logic en;
      logic [31:0] exp_rdy;
      g  = grant_of(k);
      en = !m_vld[k] || rout[k];
      if (nof(k) == 1) exp_rdy = {31'b0, en};
      else exp_rdy = (en && g >= 0) ? (32'd1 << g) : 32'd0;
      chk($sformatf("n%0d_ready_in", nof(k)), {28'b0, o_rdy[k]}, exp_rdy);
      chk($sformatf("n%0d_valid_out", nof(k)), {31'b0, o_vld[k]}, {31'b0, m_vld[k]});
      chk($sformatf("n%0d_data_out", nof(k)), o_dat[k], m_dat[k]);
      chk($sformatf("n%0d_sel_out", nof(k)), {30'b0, o_sel[k]}, 32'(m_sel[k]));
    end
  endtask

  task automatic update_model();
    for (int k = 0; k < 3; k++) begin
      int g;
      g = grant_of(k);
      if (!m_vld[k] || rout[k]) begin
        if (g >= 0) begin
          m_vld[k] = 1'b1;
          m_dat[k] = din[k][g];
          m_sel[k] = g;
          m_ptr[k] = (g + 1) % nof(k);
        end else begin
          m_vld[k] = 1'b0;
        end
      end
    end
  endtask

  // mode 0: all valid, drain; 1: directed sparse patterns; 2: all valid, stall; 3: random
  task automatic set_inputs(input int mode);
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) begin
        din[k][i] = (k == 2) ? 32'($urandom_range(0, 255)) : $urandom;
      end
      case (mode)
        0: begin vin[k] = vmask(k); rout[k] = 1'b1; end
        2: begin vin[k] = vmask(k); rout[k] = 1'b0; end
        3: begin
          vin[k]  = 4'($urandom) & vmask(k);
          rout[k] = ($urandom_range(0, 3) != 0);
        end
        default: begin
          rout[k] = 1'b1;
          if (k == 0) begin vin[k] = 4'b0100; din[k][2] = 32'hA5; end
          else if (k == 1) vin[k] = 4'b0101;
          else begin vin[k] = 4'b0001; rout[k] = ((phase_cnt % 3) != 1); end
        end
      endcase
    end
  endtask

  // Entered and left at a falling edge.
  task automatic do_cycle(input int mode);
    set_inputs(mode);
    #1;
    check_all();
    @(posedge clk);
    update_model();
    @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      vin[k] = '0;
      rout[k] = 1'b1;
      for (int i = 0; i < 4; i++) din[k][i] = '0;
    end
    #1 reset = 1'b1;
    #1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("n%0d_rst_valid", nof(k)), {31'b0, o_vld[k]}, 32'd0);
      chk($sformatf("n%0d_rst_data", nof(k)), o_dat[k], 32'd0);
      chk($sformatf("n%0d_rst_sel", nof(k)), {30'b0, o_sel[k]}, 32'd0);
    end
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // All streams valid, ready_out high: rotating 0,1,2,3,...
    for (int i = 0; i < 8; i++) begin
      do_cycle(0);
      chk("t1_sel_seq", {30'b0, o_sel[0]}, 32'(i % 4));
      chk("t1_valid", {31'b0, o_vld[0]}, 32'd1);
    end

    // Single requester (N=4), 3'b101 (N=3), ready toggling (N=1)
    for (int i = 0; i < 6; i++) begin
      phase_cnt = i;
      do_cycle(1);
      chk("t2_data_a5", o_dat[0], 32'hA5);
      chk("t2_sel_2", {30'b0, o_sel[0]}, 32'd2);
    end

    // Stall then resume
    for (int i = 0; i < 5; i++) do_cycle(2);
    for (int i = 0; i < 4; i++) do_cycle(0);

    // Asynchronous reset between edges while valid_out is high
    #2 reset = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("n%0d_async_valid", nof(k)), {31'b0, o_vld[k]}, 32'd0);
      chk($sformatf("n%0d_async_sel", nof(k)), {30'b0, o_sel[k]}, 32'd0);
      chk($sformatf("n%0d_async_data", nof(k)), o_dat[k], 32'd0);
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    do_cycle(0);
    chk("t5_first_grant", {30'b0, o_sel[0]}, 32'd0);
    chk("t5_first_valid", {31'b0, o_vld[0]}, 32'd1);
    for (int i = 0; i < 3; i++) do_cycle(0);

    // Randomized traffic with random backpressure
    for (int i = 0; i < 400; i++) do_cycle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule
